serial_port_ctrl: RTL and testbench
===================================

# serial_port_ctrl

Mode-1 (8-bit UART) serial port controller for the 8051 core. It sequences transmission of the byte the CPU writes to SBUF and assembles received frames for loading into the receive side of SBUF. It raises TI/RI set pulses for the SCON logic and sits between the SFR block and the RXD/TXD pins. Baud timing comes from an external 16x oversample enable, typically driven by the Timer 1 overflow divider.

## Interface
- OVS, 16: oversample ticks per bit; power of two, min 8
- i_clk  in  1  system clock
- i_rst  in  1  reset; synchronous, active-high
- i_baud_tick  in  1  one-cycle enable at 16x baud rate
- i_tx_start  in  1  one-cycle pulse on CPU write to SBUF
- i_tx_byte  in  8  byte to send, sampled when i_tx_start is accepted
- i_ren  in  1  SCON.REN receive enable
- i_ri  in  1  current SCON.RI value
- i_rxd  in  1  asynchronous serial input
- o_txd  out  1  serial output, idle high
- o_tx_busy  out  1  transmitter active
- o_ti_set  out  1  one-cycle pulse; set SCON.TI
- o_ri_set  out  1  one-cycle pulse; set SCON.RI
- o_rx_load  out  1  one-cycle pulse; write o_rx_byte into receive SBUF (same cycle as o_ri_set)
- o_rx_byte  out  8  last accepted received byte
- o_rb8  out  1  stop bit of last accepted frame (SCON.RB8)

## Operation
- Frame: start bit (0), 8 data bits LSB first, stop bit (1). Each bit is OVS ticks.
- TX FSM: TX_IDLE -> TX_START -> TX_DATA (8 bits, 3-bit index) -> TX_STOP -> TX_IDLE.
  - In TX_IDLE, i_tx_start is accepted: latch i_tx_byte into the shift register, clear the tick counter, go to TX_START.
  - i_tx_start while o_tx_busy=1 is ignored; in-flight data is unchanged.
  - o_ti_set pulses on the cycle TX_DATA -> TX_STOP.
- RX FSM: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE.
  - i_rxd passes through a 2-flop synchronizer. A falling edge on the synchronized line in RX_IDLE with i_ren=1 enters RX_START.
  - Each bit value is the majority of the samples at ticks 7, 8 and 9 of the bit period.
  - Start bit voted 1: false start; return to RX_IDLE with no flags.
  - At the stop-bit vote: if i_ri=0, latch o_rx_byte, set o_rb8 to the voted stop bit, and pulse o_ri_set and o_rx_load. If i_ri=1, drop the frame with no output change (overrun). Either way, go to RX_IDLE right after the vote, so a new start edge is detected from the next cycle.
- i_ren deasserted in any RX state: go to RX_IDLE on the next clock. No load, no flags.
- TX and RX are fully independent and may run concurrently.

## Timing
- Reset values: o_txd=1, o_tx_busy=0, o_ti_set=0, o_ri_set=0, o_rx_load=0, o_rx_byte=8'h00, o_rb8=0. Both FSMs go to IDLE and all counters clear. Reset takes priority over every simultaneous input.
- TX:
  - o_txd and o_tx_busy are registered. Both change the cycle after i_tx_start is accepted (o_txd=0, o_tx_busy=1).
  - Each bit lasts exactly OVS i_baud_tick pulses from its first cycle.
  - o_tx_busy falls, and o_txd stays 1, on the cycle after the OVS-th tick of the stop bit. A new i_tx_start is accepted in that same idle cycle.
- RX:
  - Synchronizer latency is 2 cycles.
  - The tick counter restarts at 0 on start-edge detection, and the votes are taken on ticks 7, 8 and 9 of each bit.
  - o_ri_set and o_rx_load are registered and asserted for exactly one cycle, on the cycle after the stop-bit vote tick.
- Tick counter wraps modulo OVS.

## Structure
- Defines.v gets:
  - TX_* and RX_* state encodings (2-bit each)
  - `UART_OVS default
  - `UART_VOTE_LO = 7
- Sub-module serial_rx_sampler:
  - 2-flop synchronizer, falling-edge detect, and 3-sample majority vote
  - outputs: o_fall (edge), o_bit (voted value), o_bit_vld (pulse on tick 9)
- TX and RX FSMs live in the top module. Target 200-300 lines total.

## Test plan
- Reset: hold i_rst=1 for 3 cycles during active TX -> all outputs at reset values, o_txd=1 the next cycle.
- TX 8'hA5, tick every 4 clk:
  - o_txd sequence is 0,1,0,1,0,0,1,0,1,1, each bit 64 clk.
  - o_ti_set pulses once at the start of the stop bit.
  - o_tx_busy is high for 640 clk.
- Second i_tx_start with 8'hFF mid-frame during TX of 8'h3C -> ignored; the line carries 8'h3C only.
- RX 8'h5A with i_ri=0, i_ren=1 -> o_rx_byte=8'h5A, o_rb8=1, and o_ri_set/o_rx_load pulse one cycle each.
- RX with i_ri=1 -> no pulses, o_rx_byte unchanged. A 1-tick glitch low on i_rxd -> false start, no pulses. A single-tick flip at tick 8 of data bit 3 -> byte still correct (majority).
- i_ren drops during data bit 4 -> no load, FSM back in RX_IDLE. The next full frame 8'h81 is received correctly.

Source files
------------

// File: rtl/serial_port_ctrl_pkg.sv
// rtl/serial_port_ctrl_pkg.sv - state encodings, timing constants and vote helper for serial_port_ctrl
package serial_port_ctrl_pkg;

  localparam int UART_OVS     = 16;
  localparam int UART_VOTE_LO = 7;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_port_ctrl_if.sv
// rtl/serial_port_ctrl_if.sv - SFR-side bundle between SBUF/SCON logic and serial_port_ctrl
interface serial_port_ctrl_if;
  logic       i_tx_start;
  logic [7:0] i_tx_byte;
  logic       i_ren;
  logic       i_ri;
  logic       o_tx_busy;
  logic       o_ti_set;
  logic       o_ri_set;
  logic       o_rx_load;
  logic [7:0] o_rx_byte;
  logic       o_rb8;

  modport slave (
    input  i_tx_start, i_tx_byte, i_ren, i_ri,
    output o_tx_busy, o_ti_set, o_ri_set, o_rx_load, o_rx_byte, o_rb8
  );

  modport master (
    output i_tx_start, i_tx_byte, i_ren, i_ri,
    input  o_tx_busy, o_ti_set, o_ri_set, o_rx_load, o_rx_byte, o_rb8
  );
endinterface

// File: rtl/serial_rx_sampler.sv
// rtl/serial_rx_sampler.sv - RXD synchronizer, start-edge detect and 3-sample majority vote
module serial_rx_sampler
  import serial_port_ctrl_pkg::*;
#(
  parameter int CW      = 4,
  parameter int VOTE_LO = 7
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_baud_tick,
  input  logic          i_rxd,
  input  logic [CW-1:0] i_cnt,
  output logic          o_fall,
  output logic          o_bit,
  output logic          o_bit_vld
);

  logic r_sync1, r_sync2, r_prev;
  logic r_s0, r_s1;

  // Flops reset to the idle-high line level so leaving reset never looks like a start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_s0    <= 1'b1;
      r_s1    <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (i_baud_tick && i_cnt == CW'(VOTE_LO))     r_s0 <= r_sync2;
      if (i_baud_tick && i_cnt == CW'(VOTE_LO + 1)) r_s1 <= r_sync2;
    end
  end

  assign o_fall    = r_prev & ~r_sync2;
  assign o_bit_vld = i_baud_tick && (i_cnt == CW'(VOTE_LO + 2));
  assign o_bit     = maj3(r_s0, r_s1, r_sync2);

endmodule

// File: rtl/serial_port_ctrl.sv
// rtl/serial_port_ctrl.sv - 8051 mode-1 UART: TX sequencer and RX frame assembler
module serial_port_ctrl
  import serial_port_ctrl_pkg::*;
#(
  parameter int OVS = UART_OVS
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_baud_tick,
  input  logic               i_rxd,
  output logic               o_txd,
  serial_port_ctrl_if.slave  io_sfr
);

  localparam int            CW      = $clog2(OVS);
  localparam int            VOTE_LO = UART_VOTE_LO * OVS / 16;
  localparam logic [CW-1:0] LAST    = CW'(OVS - 1);

  tx_state_e     r_tx_state, w_tx_next;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_next;
  logic [2:0]    r_tx_idx, w_tx_idx_next;
  logic [7:0]    r_tx_shift, w_tx_shift_next;
  logic          r_txd, w_txd_next, r_tx_busy, r_ti_set, w_ti_next;
  logic          w_tx_bit_end;

  assign w_tx_bit_end = i_baud_tick && (r_tx_cnt == LAST);

  always_comb begin
    w_tx_next       = r_tx_state;
    w_tx_cnt_next   = r_tx_cnt;
    w_tx_idx_next   = r_tx_idx;
    w_tx_shift_next = r_tx_shift;
    w_ti_next       = 1'b0;
    w_txd_next      = 1'b1;
    if (r_tx_state != TX_IDLE && i_baud_tick) w_tx_cnt_next = r_tx_cnt + 1'b1;
    case (r_tx_state)
      TX_IDLE: if (io_sfr.i_tx_start) begin
        w_tx_next       = TX_START;
        w_tx_shift_next = io_sfr.i_tx_byte;
        w_tx_cnt_next   = '0;
      end
      TX_START: if (w_tx_bit_end) begin
        w_tx_next     = TX_DATA;
        w_tx_idx_next = 3'd0;
      end
      TX_DATA: if (w_tx_bit_end) begin
        w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
        w_tx_idx_next   = r_tx_idx + 3'd1;
        if (r_tx_idx == 3'd7) begin
          w_tx_next = TX_STOP;
          w_ti_next = 1'b1;
        end
      end
      default: if (w_tx_bit_end) w_tx_next = TX_IDLE;
    endcase
    // The pin is driven from the upcoming state so it moves in step with the state register.
    case (w_tx_next)
      TX_START: w_txd_next = 1'b0;
      TX_DATA:  w_txd_next = w_tx_shift_next[0];
      default:  w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_txd      <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_ti_set   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_idx   <= w_tx_idx_next;
      r_tx_shift <= w_tx_shift_next;
      r_txd      <= w_txd_next;
      r_tx_busy  <= (w_tx_next != TX_IDLE);
      r_ti_set   <= w_ti_next;
    end
  end

  rx_state_e     r_rx_state, w_rx_next;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_next;
  logic [2:0]    r_rx_idx, w_rx_idx_next;
  logic [7:0]    r_rx_shift, w_rx_shift_next, r_rx_byte, w_rx_byte_next;
  logic          r_rb8, w_rb8_next, r_ri_set, w_ri_next;
  logic          w_fall, w_bit, w_bit_vld;

  serial_rx_sampler #(.CW(CW), .VOTE_LO(VOTE_LO)) u_sampler (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_baud_tick (i_baud_tick),
    .i_rxd       (i_rxd),
    .i_cnt       (r_rx_cnt),
    .o_fall      (w_fall),
    .o_bit       (w_bit),
    .o_bit_vld   (w_bit_vld)
  );

  always_comb begin
    w_rx_next       = r_rx_state;
    w_rx_cnt_next   = r_rx_cnt;
    w_rx_idx_next   = r_rx_idx;
    w_rx_shift_next = r_rx_shift;
    w_rx_byte_next  = r_rx_byte;
    w_rb8_next      = r_rb8;
    w_ri_next       = 1'b0;
    if (r_rx_state != RX_IDLE && i_baud_tick) w_rx_cnt_next = r_rx_cnt + 1'b1;
    if (r_rx_state != RX_IDLE && !io_sfr.i_ren) begin
      w_rx_next = RX_IDLE;
    end else begin
      case (r_rx_state)
        RX_IDLE: if (io_sfr.i_ren && w_fall) begin
          w_rx_next     = RX_START;
          w_rx_cnt_next = '0;
        end
        RX_START: if (w_bit_vld) begin
          w_rx_idx_next = 3'd0;
          w_rx_next     = w_bit ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (w_bit_vld) begin
          w_rx_shift_next = {w_bit, r_rx_shift[7:1]};
          w_rx_idx_next   = r_rx_idx + 3'd1;
          if (r_rx_idx == 3'd7) w_rx_next = RX_STOP;
        end
        default: if (w_bit_vld) begin
          // A still-set RI means the CPU has not read the last byte: drop this one.
          w_rx_next = RX_IDLE;
          if (!io_sfr.i_ri) begin
            w_rx_byte_next = r_rx_shift;
            w_rb8_next     = w_bit;
            w_ri_next      = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_byte  <= 8'h00;
      r_rb8      <= 1'b0;
      r_ri_set   <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_rx_cnt   <= w_rx_cnt_next;
      r_rx_idx   <= w_rx_idx_next;
      r_rx_shift <= w_rx_shift_next;
      r_rx_byte  <= w_rx_byte_next;
      r_rb8      <= w_rb8_next;
      r_ri_set   <= w_ri_next;
    end
  end

  assign o_txd            = r_txd;
  assign io_sfr.o_tx_busy = r_tx_busy;
  assign io_sfr.o_ti_set  = r_ti_set;
  assign io_sfr.o_ri_set  = r_ri_set;
  assign io_sfr.o_rx_load = r_ri_set;
  assign io_sfr.o_rx_byte = r_rx_byte;
  assign io_sfr.o_rb8     = r_rb8;

endmodule

// File: tb/tb_serial_port_ctrl.sv
// tb/tb_serial_port_ctrl.sv - randomized bench for serial_port_ctrl against a frame-level reference
module tb_serial_port_ctrl;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic baud_tick = 1'b0;
  logic rxd = 1'b1;
  logic txd;
  int   tick_ph = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  int   ri_seen = 0, load_seen = 0;

  serial_port_ctrl_if sfr();

  serial_port_ctrl dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_baud_tick (baud_tick),
    .i_rxd       (rxd),
    .o_txd       (txd),
    .io_sfr      (sfr)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    forever begin
      @(negedge i_clk);
      tick_ph   = (tick_ph == 3) ? 0 : tick_ph + 1;
      baud_tick = (tick_ph == 0);
    end
  end

  // Reference: TX as a 10-bit frame indexed by bit position, RX as a tick index since the start edge.
  logic       m_txd = 1'b1, m_busy = 1'b0, m_ti = 1'b0, m_ri = 1'b0, m_rb8 = 1'b0;
  logic [7:0] m_byte = 8'h00, m_data = 8'h00;
  logic [9:0] m_frame = 10'h3FF;
  logic [3:0] m_pos = 4'd0;
  int         m_tcnt = 0, m_k = 0;
  bit         m_rx_on = 1'b0;
  logic       h1 = 1'b1, h2 = 1'b1, h3 = 1'b1, sa = 1'b1, sb = 1'b1, v;

  always @(posedge i_clk) begin
    m_ti = 1'b0;
    m_ri = 1'b0;
    if (i_rst) begin
      m_busy = 1'b0; m_byte = 8'h00; m_rb8 = 1'b0; m_rx_on = 1'b0;
      h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
    end else begin
      if (!m_busy) begin
        if (sfr.i_tx_start) begin
          m_busy = 1'b1; m_frame = {1'b1, sfr.i_tx_byte, 1'b0}; m_pos = 4'd0; m_tcnt = 0;
        end
      end else if (baud_tick) begin
        m_tcnt++;
        if (m_tcnt == 16) begin
          m_tcnt = 0;
          m_pos  = m_pos + 4'd1;
          if (m_pos == 4'd9)  m_ti = 1'b1;
          if (m_pos == 4'd10) m_busy = 1'b0;
        end
      end
      if (m_rx_on && !sfr.i_ren) begin
        m_rx_on = 1'b0;
      end else if (m_rx_on) begin
        if (baud_tick) begin
          if (m_k % 16 == 7) sa = h2;
          if (m_k % 16 == 8) sb = h2;
          if (m_k % 16 == 9) begin
            v = (int'(sa) + int'(sb) + int'(h2)) >= 2;
            if (m_k / 16 == 0) begin
              if (v) m_rx_on = 1'b0;
            end else if (m_k / 16 <= 8) begin
              m_data[m_k / 16 - 1] = v;
            end else begin
              m_rx_on = 1'b0;
              if (!sfr.i_ri) begin m_byte = m_data; m_rb8 = v; m_ri = 1'b1; end
            end
          end
          m_k++;
        end
      end else if (sfr.i_ren && h3 && !h2) begin
        m_rx_on = 1'b1;
        m_k = 0;
      end
      h3 = h2; h2 = h1; h1 = rxd;
    end
    m_txd = m_busy ? m_frame[m_pos] : 1'b1;
  end

  logic [13:0] act, exp_v;
  always @(negedge i_clk) begin
    if (chk_en) begin
      act   = {txd, sfr.o_tx_busy, sfr.o_ti_set, sfr.o_ri_set, sfr.o_rx_load, sfr.o_rx_byte, sfr.o_rb8};
      exp_v = {m_txd, m_busy, m_ti, m_ri, m_ri, m_byte, m_rb8};
      n_cmp++;
      if (act !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t got=%h want=%h", $time, act, exp_v);
      end
      if (sfr.o_ri_set)  ri_seen++;
      if (sfr.o_rx_load) load_seen++;
    end
  end

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic tx_send(input logic [7:0] b, input bit align);
    int guard = 0;
    if (align) while (!baud_tick && guard < 8) begin step(); guard++; end
    sfr.i_tx_start = 1'b1;
    sfr.i_tx_byte  = b;
    step();
    sfr.i_tx_start = 1'b0;
  endtask

  // Sends an aligned frame and records the line at each bit centre, busy length and TI timing.
  task automatic tx_measure(input logic [7:0] b, input bit inject,
                            output logic [9:0] seq, output int busy_n, output int ti_n, output int ti_at);
    seq = '0; busy_n = 0; ti_n = 0; ti_at = -1;
    tx_send(b, 1'b1);
    for (int i = 0; i < 700; i++) begin
      if (sfr.o_tx_busy) busy_n++;
      if (i % 64 == 32 && i < 640) seq[i / 64] = txd;
      if (sfr.o_ti_set) begin ti_n++; ti_at = i; end
      sfr.i_tx_start = inject && (i == 200);
      if (inject && i == 200) sfr.i_tx_byte = 8'hFF;
      step();
    end
    sfr.i_tx_start = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, input int flip, input int drop_at);
    logic [9:0] f;
    logic       bv;
    f = {stop, b, 1'b0};
    for (int c = 0; c < 640; c++) begin
      bv = f[c / 64];
      if (c / 64 == flip && c % 64 >= 32 && c % 64 < 36) bv = ~bv;
      if (c == drop_at) sfr.i_ren = 1'b0;
      rxd = bv;
      step();
    end
    rxd = 1'b1;
    repeat (40) step();
    sfr.i_ren = 1'b1;
  endtask

  task automatic tx_rand();
    repeat ($urandom_range(0, 30)) step();
    tx_send(8'($urandom), 1'b0);
    repeat (660) step();
  endtask

  task automatic rx_rand();
    sfr.i_ri = 1'($urandom_range(0, 1));
    rx_frame(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 10)), -1);
    sfr.i_ri = 1'b0;
  endtask

  logic [9:0] seq;
  int busy_n, ti_n, ti_at, ri0, ld0;

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sfr.i_tx_start = 1'b0; sfr.i_tx_byte = 8'h00; sfr.i_ren = 1'b1; sfr.i_ri = 1'b0;
    i_rst = 1'b1;
    step();
    chk_en = 1'b1;
    repeat (2) step();
    i_rst = 1'b0;
    step();
    check("reset_txd", 32'(txd), 32'd1);

    tx_send(8'h96, 1'b0);
    repeat (100) step();
    check("busy_before_reset", 32'(sfr.o_tx_busy), 32'd1);
    i_rst = 1'b1;
    for (int r = 0; r < 3; r++) begin
      step();
      check("reset_outputs", {18'd0, txd, sfr.o_tx_busy, sfr.o_ti_set, sfr.o_ri_set,
            sfr.o_rx_load, sfr.o_rx_byte, sfr.o_rb8}, {18'd0, 14'b1_0_0_0_0_00000000_0});
    end
    i_rst = 1'b0;
    step();
    check("post_reset_txd", 32'(txd), 32'd1);
    check("post_reset_busy", 32'(sfr.o_tx_busy), 32'd0);

    tx_measure(8'hA5, 1'b0, seq, busy_n, ti_n, ti_at);
    check("a5_sequence", 32'(seq), 32'(10'b1101001010));
    check("a5_busy_len", 32'(busy_n), 32'd640);
    check("a5_ti_count", 32'(ti_n), 32'd1);
    check("a5_ti_at_stop", 32'(ti_at), 32'd576);

    tx_measure(8'h3C, 1'b1, seq, busy_n, ti_n, ti_at);
    check("3c_ignores_ff", 32'(seq), 32'(10'b1001111000));
    check("3c_busy_len", 32'(busy_n), 32'd640);

    ri0 = ri_seen; ld0 = load_seen;
    rx_frame(8'h5A, 1'b1, -1, -1);
    check("rx_5a_byte", 32'(sfr.o_rx_byte), 32'h5A);
    check("rx_5a_rb8", 32'(sfr.o_rb8), 32'd1);
    check("rx_5a_ri_pulses", 32'(ri_seen - ri0), 32'd1);
    check("rx_5a_load_pulses", 32'(load_seen - ld0), 32'd1);

    ri0 = ri_seen; ld0 = load_seen;
    sfr.i_ri = 1'b1;
    rx_frame(8'h33, 1'b1, -1, -1);
    sfr.i_ri = 1'b0;
    check("overrun_byte_kept", 32'(sfr.o_rx_byte), 32'h5A);
    check("overrun_no_pulse", 32'(ri_seen - ri0 + load_seen - ld0), 32'd0);

    ri0 = ri_seen;
    rxd = 1'b0; repeat (4) step();
    rxd = 1'b1; repeat (200) step();
    check("glitch_no_pulse", 32'(ri_seen - ri0), 32'd0);

    rx_frame(8'hC3, 1'b0, 4, -1);
    check("flip_byte", 32'(sfr.o_rx_byte), 32'hC3);
    check("flip_rb8_zero", 32'(sfr.o_rb8), 32'd0);

    ld0 = load_seen;
    rx_frame(8'h77, 1'b1, -1, 64 * 5 + 20);
    check("ren_drop_no_load", 32'(load_seen - ld0), 32'd0);
    check("ren_drop_byte_kept", 32'(sfr.o_rx_byte), 32'hC3);
    rx_frame(8'h81, 1'b1, -1, -1);
    check("after_drop_81", 32'(sfr.o_rx_byte), 32'h81);
    check("after_drop_rb8", 32'(sfr.o_rb8), 32'd1);

    for (int it = 0; it < 6; it++) begin
      fork
        tx_rand();
        rx_rand();
      join
    end
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
